// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-cycle right-shift/rotate sequencer.
package shift_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;
  localparam int STG_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_LSR = 2'd0,
    MODE_ASR = 2'd1,
    MODE_ROR = 2'd2
  } mode_t;

  // Rotate takes priority over arithmetic fill.
  function automatic mode_t mode_of(input logic rotate, input logic sra);
    if (rotate) begin
      return MODE_ROR;
    end else if (sra) begin
      return MODE_ASR;
    end
    return MODE_LSR;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One fixed-distance right-shift/rotate stage (distance 2^k), purely combinational.
// Zero latency, no handshake; passes w through unchanged when en is low.
module shift_stage
  import shift_pkg::*;
(
  input  logic [WIDTH-1:0] w,
  input  logic [STG_W-1:0] k,
  input  logic             en,
  input  mode_t            mode,
  output logic [WIDTH-1:0] y
);

  logic [SHAMT_W-1:0] d;

  always_comb begin
    d = SHAMT_W'(1) << k;
    y = w;
    if (en) begin
      case (mode)
        MODE_ROR: y = WIDTH'({w, w} >> d);
        MODE_ASR: y = $unsigned($signed(w) >>> d);
        default:  y = w >> d;
      endcase
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer walking one operand through stages 16,8,4,2,1, one per clock: 5 clocks accept-to-result.
// in_ready only in IDLE; result held stable in DONE until out_ready.
module shift_seq_ctrl #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic               in_sra,
  input  logic               in_rotate,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  import shift_pkg::*;

  state_t               state_q, state_d;
  logic [STG_W-1:0]     k_q;
  logic [WIDTH-1:0]     w_q;
  logic [SHAMT_W-1:0]   shamt_q;
  mode_t                mode_q;
  logic [WIDTH-1:0]     stage_y;

  shift_stage u_stage (
    .w    (w_q),
    .k    (k_q),
    .en   (shamt_q[k_q]),
    .mode (mode_q),
    .y    (stage_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_RUN;
      ST_RUN:  if (k_q == '0) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operands are captured only on acceptance; later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q     <= '0;
      w_q     <= '0;
      shamt_q <= '0;
      mode_q  <= MODE_LSR;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            w_q     <= in_data;
            shamt_q <= in_shamt;
            mode_q  <= mode_of(in_rotate, in_sra);
            k_q     <= STG_W'(SHAMT_W - 1);
          end
        end
        ST_RUN: begin
          w_q <= stage_y;
          if (k_q != '0) begin
            k_q <= k_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = w_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: modes, latency, backpressure, reset abort.
module tb_shift_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic        in_sra;
  logic        in_rotate;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_sra    (in_sra),
    .in_rotate (in_rotate),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Counts clocks after the accept edge until out_valid is seen (bounded).
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_val({tag, "_ovalid_after"}, {31'd0, out_valid}, 32'd0);
    check_val({tag, "_iready_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] data, input logic [4:0] sh,
                        input logic sra, input logic rot, input logic [31:0] exp);
    int lat;
    check_val({tag, "_iready"}, {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_data   = data;
    in_shamt  = sh;
    in_sra    = sra;
    in_rotate = rot;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 32'h5A5A_5A5A;
    in_shamt = 5'd3;
    check_val({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_result(lat);
    check_val({tag, "_lat"}, lat, 32'd5);
    check_val({tag, "_data"}, out_data, exp);
    drain(tag);
  endtask

  initial begin
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_sra    = 1'b0;
    in_rotate = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_iready", {31'd0, in_ready}, 32'd1);
    check_val("rst_ovalid", {31'd0, out_valid}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_odata", out_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("lsr8",    32'h1234_5678, 5'd8,  1'b0, 1'b0, 32'h0012_3456);
    run_op("asr8",    32'h8765_4321, 5'd8,  1'b1, 1'b0, 32'hFF87_6543);
    run_op("asr31",   32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'hFFFF_FFFF);
    run_op("lsr31",   32'h8000_0000, 5'd31, 1'b0, 1'b0, 32'h0000_0001);
    run_op("asrpos",  32'h7F00_0000, 5'd4,  1'b1, 1'b0, 32'h07F0_0000);
    run_op("rorprio", 32'hFEDC_BA98, 5'd8,  1'b1, 1'b1, 32'h98FE_DCBA);
    run_op("ror4",    32'hC0FF_EE01, 5'd4,  1'b0, 1'b1, 32'h1C0F_FEE0);
    run_op("ror31",   32'h8000_0001, 5'd31, 1'b0, 1'b1, 32'h0000_0003);
    run_op("sh0lsr",  32'hABCD_EF01, 5'd0,  1'b0, 1'b0, 32'hABCD_EF01);
    run_op("sh0asr",  32'hABCD_EF01, 5'd0,  1'b1, 1'b0, 32'hABCD_EF01);
    run_op("sh0ror",  32'hABCD_EF01, 5'd0,  1'b0, 1'b1, 32'hABCD_EF01);

    // Backpressure: result held while a new request waits on in_valid.
    in_valid  = 1'b1;
    in_data   = 32'h1234_5678;
    in_shamt  = 5'd4;
    in_sra    = 1'b0;
    in_rotate = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_data  = 32'hDEAD_BEEF;
    in_shamt = 5'd16;
    wait_result(lat);
    check_val("bp_lat", lat, 32'd5);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("bp_hold_data", out_data, 32'h0123_4567);
      check_val("bp_hold_ovalid", {31'd0, out_valid}, 32'd1);
      check_val("bp_hold_iready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_val("bp_iready_after", {31'd0, in_ready}, 32'd1);
    check_val("bp_ovalid_after", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check_val("bp_accepted_busy", {31'd0, busy}, 32'd1);
    wait_result(lat);
    check_val("bp2_lat", lat, 32'd5);
    check_val("bp2_data", out_data, 32'h0000_DEAD);
    drain("bp2");

    // Reset asserted just after E3 aborts the operation.
    in_valid  = 1'b1;
    in_data   = 32'h1234_5678;
    in_shamt  = 5'd8;
    in_sra    = 1'b0;
    in_rotate = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_val("abort_ovalid", {31'd0, out_valid}, 32'd0);
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    check_val("abort_iready", {31'd0, in_ready}, 32'd1);
    check_val("abort_odata", out_data, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check_val("abort_no_ovalid", {31'd0, out_valid}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    run_op("post_rst", 32'hF000_000F, 5'd2, 1'b1, 1'b0, 32'hFC00_0003);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Multi-cycle sequencer for the right-shift/rotate datapath. It accepts one 32-bit operand with a 5-bit shift amount and a mode over a valid/ready handshake. It then walks the operand through the fixed-distance stages (16, 8, 4, 2, 1), one stage per clock, applying each stage only when the matching shift-amount bit is set. The result is presented on a valid/ready output port. The block sits between the instruction/operand source and the consumer of shifted results, and replaces a single-cycle five-stage combinational chain when timing requires it.

## Interface
- WIDTH, 32, operand width; fixed at 32, other values unsupported
- SHAMT_W, 5, shift-amount width (log2 WIDTH)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  request present
- in_ready  out  1  block can accept request
- in_data  in  WIDTH  operand
- in_shamt  in  SHAMT_W  shift amount 0..31
- in_sra  in  1  arithmetic right shift (sign fill)
- in_rotate  in  1  rotate right; has priority over in_sra
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  result
- busy  out  1  high in RUN or DONE

## Operation
- States:
  - IDLE: in_ready=1
  - RUN: stage counter k = 4..0
  - DONE: out_valid=1
- IDLE → RUN on in_valid && in_ready.
  - Latch in_data into the working register.
  - Latch shamt and mode into holding registers.
  - Set k=4.
  - Inputs are ignored after acceptance.
- RUN, each cycle: stage distance d = 2^k.
  - If shamt[k] is set, the working register becomes its stage-shifted value. Otherwise it is unchanged.
  - k decrements.
  - RUN → DONE when k==0 has been processed.
- Stage functions:
  - rotate=1: {w[d-1:0], w[31:d]}.
  - rotate=0, sra=1: d copies of w[31], then w[31:d].
  - rotate=0, sra=0: d zeros, then w[31:d].
- Sign fill uses the working register's current bit 31 at each stage. This is equivalent to the original sign, because arithmetic fill preserves it.
- DONE: out_data = working register, out_valid=1. DONE → IDLE on out_ready. out_data stays stable while out_valid && !out_ready.
- shamt=0 still runs all five stages; the result equals the operand.
- in_ready=0 in RUN and DONE. There is no overlap; the next request is accepted earliest in the cycle after the DONE → IDLE handshake.

## Timing
- Reset values:
  - state=IDLE, k=0.
  - Working register and out_data = 0.
  - in_ready=1, out_valid=0, busy=0.
- Reset asserted in RUN or DONE aborts immediately. The in-flight result is lost and no out_valid pulse is produced.
- Latency is fixed:
  - Accept edge E0.
  - Stages execute on edges E1..E5.
  - out_valid is high from after E5.
  - This gives 5 clocks from accept to result, independent of shamt and mode.
- Best-case throughput: one operation per 7 clocks (accept, 5 RUN, DONE with out_ready=1).
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Structure
- shift_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - WIDTH / SHAMT_W constants;
  - the mode encoding (LSR, ASR, ROR) derived from {rotate, sra}.
- Natural sub-module: shift_stage, a combinational one-stage shifter.
  - Inputs: w, distance select k, enable, mode.
  - Output: shifted word.
  - Instantiated once and time-multiplexed by the sequencer.
- The sequencer (FSM, counter, registers) lives in shift_seq_ctrl.

## Test plan
- LSR: 0x12345678, shamt=8 → out_data=0x00123456, out_valid exactly 5 clocks after accept.
- ASR: 0x87654321, shamt=8 → 0xFF876543. ASR 0x80000000, shamt=31 → 0xFFFFFFFF. LSR 0x80000000, shamt=31 → 0x00000001.
- ROR with priority: 0xFEDCBA98, shamt=8, rotate=1, sra=1 → 0x98FEDCBA. 0xC0FFEE01, shamt=4, rotate=1 → 0x1C0FFEE0.
- shamt=0, 0xABCDEF01, any mode → 0xABCDEF01 after 5 clocks.
- Backpressure: hold out_ready=0 for 3 clocks after out_valid, with in_valid held high and new data applied.
  - Required: out_data is stable, in_ready=0, and the new request is not taken.
  - After out_ready, in_ready=1 the next cycle and the pending request is accepted.
- Reset mid-RUN (assert rst at E3):
  - Required: outputs go to their reset values asynchronously, with no out_valid.
  - After release, a fresh request completes normally.
